// File: rtl/aq_fadd_norm_shift_pipe.sv
// FADD normalisation shifter: two-stage valid/ready pipeline.
// S1 selects the shift count, S2 shifts and adjusts the exponent.
module aq_fadd_norm_shift_pipe #(
  parameter int WIDTH    = 28,
  parameter int CNT_W    = 5,
  parameter int EXP_W    = 10,
  parameter bit CLAMP_EN = 1'b1
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_mode_lzc,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [EXP_W-1:0] out_exp,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero,
  output logic             out_uflow
);

  localparam int CMP_W = (EXP_W > CNT_W) ? EXP_W : CNT_W;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [EXP_W-1:0] exp;
    logic [CNT_W-1:0] cnt;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [EXP_W-1:0] exp;
    logic [CNT_W-1:0] cnt;
    logic             zero;
    logic             uflow;
  } s2_t;

  // Highest set bit wins; all-zero input reports WIDTH.
  function automatic logic [CNT_W-1:0] lzc(
    input logic [WIDTH-1:0] d
  );
    logic [CNT_W-1:0] n;
    n = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) n = CNT_W'(WIDTH - 1 - i);
    end
    return n;
  endfunction

  logic             s1_vld;
  logic             s2_vld;
  logic             s2_adv;
  s1_t              s1_q;
  s1_t              s1_d;
  s2_t              s2_q;
  s2_t              s2_d;
  logic [CMP_W-1:0] req_w;
  logic [CMP_W-1:0] exp_w;
  logic             uflow;
  logic [CNT_W-1:0] applied;
  logic [WIDTH-1:0] shifted;

  assign s2_adv = !s2_vld || out_rdy;
  assign in_rdy = !s1_vld || s2_adv;

  always_comb begin
    s1_d.data = in_data;
    s1_d.exp  = in_exp;
    unique case (1'b1)
      in_mode_lzc: s1_d.cnt = lzc(in_data);
      default:     s1_d.cnt = in_cnt;
    endcase
  end

  // Clamped shift never exceeds the exponent, so exp fits in CNT_W then.
  always_comb begin
    req_w   = CMP_W'(s1_q.cnt);
    exp_w   = CMP_W'(s1_q.exp);
    uflow   = req_w > exp_w;
    applied = (CLAMP_EN && uflow) ? CNT_W'(s1_q.exp) : s1_q.cnt;
    shifted = (int'(applied) >= WIDTH) ? '0 : (s1_q.data << applied);
  end

  always_comb begin
    s2_d.data  = shifted;
    s2_d.exp   = s1_q.exp - EXP_W'(applied);
    s2_d.cnt   = applied;
    s2_d.zero  = ~|shifted;
    s2_d.uflow = uflow;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      if (in_rdy) begin
        s1_vld <= in_vld;
        if (in_vld) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_q <= s2_d;
      end
    end
  end

  assign out_vld   = s2_vld;
  assign out_data  = s2_q.data;
  assign out_exp   = s2_q.exp;
  assign out_cnt   = s2_q.cnt;
  assign out_zero  = s2_q.zero;
  assign out_uflow = s2_q.uflow;

endmodule

// File: tb/tb_aq_fadd_norm_shift_pipe.sv
// Bench for aq_fadd_norm_shift_pipe: clamped and unclamped instances
// driven in lockstep, checked against an arithmetic scoreboard.
module tb_aq_fadd_norm_shift_pipe;

  localparam int W  = 28;
  localparam int CW = 5;
  localparam int EW = 10;

  typedef struct {
    logic [44:0] r;
    int          cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          cpurst;
  logic          in_vld;
  logic [W-1:0]  in_data;
  logic [EW-1:0] in_exp;
  logic          in_mode_lzc;
  logic [CW-1:0] in_cnt;
  logic          out_rdy;

  logic          in_rdy_a    [2];
  logic          out_vld_a   [2];
  logic [W-1:0]  out_data_a  [2];
  logic [EW-1:0] out_exp_a   [2];
  logic [CW-1:0] out_cnt_a   [2];
  logic          out_zero_a  [2];
  logic          out_uflow_a [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    aq_fadd_norm_shift_pipe #(
      .WIDTH(W), .CNT_W(CW), .EXP_W(EW), .CLAMP_EN(g == 0)
    ) u_dut (
      .forever_cpuclk(clk),
      .cpurst        (cpurst),
      .in_vld        (in_vld),
      .in_rdy        (in_rdy_a[g]),
      .in_data       (in_data),
      .in_exp        (in_exp),
      .in_mode_lzc   (in_mode_lzc),
      .in_cnt        (in_cnt),
      .out_vld       (out_vld_a[g]),
      .out_rdy       (out_rdy),
      .out_data      (out_data_a[g]),
      .out_exp       (out_exp_a[g]),
      .out_cnt       (out_cnt_a[g]),
      .out_zero      (out_zero_a[g]),
      .out_uflow     (out_uflow_a[g])
    );
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          cnt   = 0;
  int          cyc   = 0;
  bit          lat_chk = 0;
  beat_t       q0[$];
  beat_t       q1[$];
  bit          stall_prev [2];
  logic [44:0] prev_out   [2];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: leading zeros from bit length, plain integer arithmetic.
  function automatic logic [44:0] ref_norm(logic [W-1:0] d, int e, bit m,
                                           int c, bit clamp);
    int          req;
    int          app;
    int          oe;
    bit          uf;
    logic [63:0] od;
    req = m ? (W - $clog2(64'(d) + 64'd1)) : c;
    uf  = req > e;
    app = (clamp && uf) ? e : req;
    od  = (app >= W) ? 64'd0 : ((64'(d) << app) & ((64'd1 << W) - 1));
    oe  = ((e - app) % 1024 + 1024) % 1024;
    return {od[W-1:0], EW'(oe), CW'(app), od == 64'd0, uf};
  endfunction

  function automatic logic [44:0] dut_out(int g);
    return {out_data_a[g], out_exp_a[g], out_cnt_a[g],
            out_zero_a[g], out_uflow_a[g]};
  endfunction

  task automatic step(input bit v, input logic [W-1:0] d,
                      input logic [EW-1:0] e, input bit m,
                      input logic [CW-1:0] c, input bit ordy,
                      output bit acc);
    bit          ofire;
    beat_t       b;
    logic [44:0] cur;
    in_vld = v; in_data = d; in_exp = e;
    in_mode_lzc = m; in_cnt = c; out_rdy = ordy;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("in_rdy", in_rdy_a[g], !(cnt == 2 && !ordy));
      if (cnt == 0) check("vld_empty", out_vld_a[g], 1'b0);
      if (cnt == 2) check("vld_full", out_vld_a[g], 1'b1);
      cur = dut_out(g);
      if (stall_prev[g]) check("hold", cur, prev_out[g]);
      if (out_vld_a[g] && ordy) begin
        if (g == 0 ? q0.size() == 0 : q1.size() == 0)
          check("unexpected_beat", 1'b1, 1'b0);
        else begin
          b = (g == 0) ? q0.pop_front() : q1.pop_front();
          check(g == 0 ? "beat_clamp" : "beat_noclamp", cur, b.r);
          if (lat_chk) check("latency", 64'(cyc - b.cyc), 64'd2);
        end
      end
      stall_prev[g] = out_vld_a[g] && !ordy;
      prev_out[g]   = cur;
    end
    acc   = v && in_rdy_a[0];
    ofire = out_vld_a[0] && ordy;
    if (acc) begin
      b.cyc = cyc;
      b.r = ref_norm(d, int'(e), m, int'(c), 1'b1);
      q0.push_back(b);
      b.r = ref_norm(d, int'(e), m, int'(c), 1'b0);
      q1.push_back(b);
    end
    @(posedge clk);
    cnt = cnt + int'(acc) - int'(ofire);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [EW-1:0] e,
                      input bit m, input logic [CW-1:0] c);
    bit acc;
    step(1'b1, d, e, m, c, 1'b1, acc);
    if (!acc) check("send_accept", acc, 1'b1);
  endtask

  task automatic drain();
    bit acc;
    int k = 0;
    while (cnt > 0 && k < 20) begin
      step(1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
      k++;
    end
    if (cnt > 0) check("drain_timeout", 64'(cnt), 64'd0);
  endtask

  task automatic rand_beat(output logic [W-1:0] d, output logic [EW-1:0] e,
                           output bit m, output logic [CW-1:0] c);
    logic [31:0] r;
    r = $urandom;
    d = W'(r[W-1:0] >> $urandom_range(0, W));
    e = ($urandom % 2) ? EW'($urandom_range(0, 40)) : EW'($urandom);
    m = ($urandom % 3) != 0;
    c = CW'($urandom);
  endtask

  initial begin
    bit            acc;
    int            sent;
    int            k;
    logic [W-1:0]  d;
    logic [EW-1:0] e;
    bit            m;
    logic [CW-1:0] c;
    stall_prev = '{1'b0, 1'b0};
    cpurst = 1'b1; in_vld = 1'b0; in_data = '0; in_exp = '0;
    in_mode_lzc = 1'b0; in_cnt = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_vld", out_vld_a[g], 1'b0);
      check("rst_out", dut_out(g), 45'd0);
    end
    @(posedge clk);
    #1 cpurst = 1'b0;

    lat_chk = 1'b1;
    send(28'h0000100, 10'd100, 1'b1, 5'd0);
    send(28'h0000100, 10'd5,   1'b1, 5'd0);
    send(28'hFFFFFFF, 10'd40,  1'b0, 5'd30);
    send(28'h0000000, 10'd3,   1'b1, 5'd0);
    send(28'h8000000, 10'd0,   1'b1, 5'd0);
    send(28'h0000001, 10'd27,  1'b1, 5'd0);
    send(28'h1234567, 10'd2,   1'b0, 5'd31);
    drain();
    lat_chk = 1'b0;

    sent = 0; k = 0;
    while (sent < 4 && k < 20) begin
      rand_beat(d, e, m, c);
      step(1'b1, d, e, m, c, k >= 3, acc);
      sent += int'(acc);
      k++;
    end
    if (sent < 4) check("bp_send_timeout", 64'(sent), 64'd4);
    drain();

    for (int i = 0; i < 1500; i++) begin
      rand_beat(d, e, m, c);
      step(($urandom % 4) != 0, d, e, m, c, ($urandom % 3) != 0, acc);
    end
    drain();

    for (int i = 0; i < 2; i++) begin
      rand_beat(d, e, m, c);
      step(1'b1, d, e, m, c, 1'b0, acc);
    end
    check("inflight", 64'(cnt), 64'd2);
    cpurst = 1'b1; in_vld = 1'b1; out_rdy = 1'b0;
    @(posedge clk);
    #1 cpurst = 1'b0;
    q0.delete(); q1.delete();
    cnt = 0;
    stall_prev = '{1'b0, 1'b0};
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, '0, i > 0, acc);

    for (int i = 0; i < 300; i++) begin
      rand_beat(d, e, m, c);
      step(($urandom % 2) != 0, d, e, m, c, ($urandom % 4) != 0, acc);
    end
    drain();
    check("q0_empty", 64'(q0.size()), 64'd0);
    check("q1_empty", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
